// File: rtl/memfifo_pkg.sv
// memfifo_pkg: shared types and constants for the memfifo write-side arbiter.
package memfifo_pkg;

  localparam int unsigned HW_W   = 16;
  localparam int unsigned WORD_W = 32;

  // Source indices on the shared FIFO write port
  localparam logic SRC_USB  = 1'b0;
  localparam logic SRC_TEST = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/memfifo_wr_arbiter_if.sv
// memfifo_wr_arbiter_if: two halfword source streams plus the 32-bit FIFO write port.
// master = arbiter side, slave = sources/FIFO side.
interface memfifo_wr_arbiter_if;
  import memfifo_pkg::*;

  logic [HW_W-1:0]   s0_data;
  logic              s0_valid;
  logic              s0_ready;
  logic [HW_W-1:0]   s1_data;
  logic              s1_valid;
  logic              s1_ready;
  logic [WORD_W-1:0] DI;
  logic              WREN;
  logic              FULL;

  modport master (
    input  s0_data, s0_valid, s1_data, s1_valid, FULL,
    output s0_ready, s1_ready, DI, WREN
  );

  modport slave (
    output s0_data, s0_valid, s1_data, s1_valid, FULL,
    input  s0_ready, s1_ready, DI, WREN
  );

endinterface

// File: rtl/wr_arb_pack.sv
// wr_arb_pack: 16->32 packer. First halfword goes to lo, second loads DI={data,lo}.
// DI is held while FULL; WREN = out_valid && !FULL.
// Optional WR_ARB_STATS_EN: a 1-bit source tag travels with each DI word.
module wr_arb_pack
  import memfifo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fire,
  input  logic [HW_W-1:0]   i_data,
`ifdef WR_ARB_STATS_EN
  input  logic              i_tag,
  output logic              o_tag,
`endif
  input  logic              i_full,
  output logic [WORD_W-1:0] o_di,
  output logic              o_wren,
  output logic              o_hw,
  output logic              o_out_valid
);

  logic              r_hw;
  logic              r_out_valid;
  logic [HW_W-1:0]   r_lo;
  logic [WORD_W-1:0] r_di;
  logic              w_wren;

  assign w_wren      = r_out_valid && !i_full;
  assign o_wren      = w_wren;
  assign o_di        = r_di;
  assign o_hw        = r_hw;
  assign o_out_valid = r_out_valid;

  // Halfword assembly and output word hold; a reload in the write cycle keeps out_valid set
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hw        <= 1'b0;
      r_out_valid <= 1'b0;
      r_lo        <= '0;
      r_di        <= '0;
    end else begin
      if (i_fire && !r_hw) begin
        r_lo <= i_data;
        r_hw <= 1'b1;
      end
      if (i_fire && r_hw) begin
        r_di        <= {i_data, r_lo};
        r_out_valid <= 1'b1;
        r_hw        <= 1'b0;
      end else if (w_wren) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef WR_ARB_STATS_EN
  logic r_tag;
  assign o_tag = r_tag;

  // Source tag captured together with the DI word it describes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            r_tag <= 1'b0;
    else if (i_fire && r_hw) r_tag <= i_tag;
  end
`endif

endmodule

// File: rtl/memfifo_wr_arbiter.sv
// memfifo_wr_arbiter: shares the 32-bit FIFO write port between source 0 (USB)
// and source 1 (test gen) with burst round-robin. Optional WR_ARB_STATS_EN enables
// the per-source written-word counters cnt0/cnt1 (constant 0 otherwise).
module memfifo_wr_arbiter
  import memfifo_pkg::*;
#(
  parameter int unsigned BURST = 16
)(
  input  logic                 ifclk,
  input  logic                 reset_n,
  input  logic [1:0]           en,
  memfifo_wr_arbiter_if.master bus,
  output logic [1:0]           grant,
  output logic [31:0]          cnt0,
  output logic [31:0]          cnt1
);

  arb_state_e  r_state;
  logic        r_last;
  logic [15:0] r_beat;
  logic [1:0]  r_grant;

  logic        w_hw, w_out_valid, w_wren, w_ok;
  logic        w_rdy0, w_rdy1, w_fire;
  logic [15:0] w_data;
  logic        w_own_valid, w_hw_nxt, w_arb;
  logic [15:0] w_beat_nxt;
  logic [1:0]  w_cand;
  logic        w_other, w_win, w_win_vld;

  // Handshake, next-cycle packer view and arbitration decision.
  // The arbitration point is evaluated on next-cycle hw/beat so that a burst
  // ending on this edge hands over without an idle cycle.
  always_comb begin
    w_ok        = !w_hw || !w_out_valid || !bus.FULL;
    w_rdy0      = (r_state == OWN0) && w_ok;
    w_rdy1      = (r_state == OWN1) && w_ok;
    w_fire      = (bus.s0_valid && w_rdy0) || (bus.s1_valid && w_rdy1);
    w_data      = (r_state == OWN1) ? bus.s1_data : bus.s0_data;
    w_own_valid = 1'b0;
    if (r_state == OWN0) w_own_valid = bus.s0_valid;
    if (r_state == OWN1) w_own_valid = bus.s1_valid;
    w_hw_nxt    = w_hw ^ w_fire;
    w_beat_nxt  = r_beat + {15'd0, (w_fire && w_hw)};
    w_arb       = !w_hw_nxt && ((r_state == IDLE) || (w_beat_nxt == 16'(BURST)) || !w_own_valid);
    w_cand      = en & {bus.s1_valid, bus.s0_valid};
    w_other     = ~r_last;
    w_win       = r_last;
    w_win_vld   = 1'b0;
    if (w_cand[w_other]) begin
      w_win     = w_other;
      w_win_vld = 1'b1;
    end else if (w_cand[r_last]) begin
      w_win_vld = 1'b1;
    end
  end

  assign bus.s0_ready = w_rdy0;
  assign bus.s1_ready = w_rdy1;
  assign bus.WREN     = w_wren;
  assign grant        = r_grant;

  // Ownership FSM with registered grant, last-granted pointer and burst beat counter
  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_last  <= SRC_TEST;
      r_beat  <= '0;
      r_grant <= '0;
    end else if (w_arb) begin
      r_beat <= '0;
      if (w_win_vld) begin
        r_state <= (w_win == SRC_USB) ? OWN0 : OWN1;
        r_grant <= (w_win == SRC_USB) ? 2'b01 : 2'b10;
        r_last  <= w_win;
      end else begin
        r_state <= IDLE;
        r_grant <= '0;
      end
    end else begin
      r_beat <= w_beat_nxt;
    end
  end

`ifdef WR_ARB_STATS_EN
  logic        w_tag;
  logic [31:0] r_cnt0, r_cnt1;

  wr_arb_pack u_pack (
    .i_clk       (ifclk),
    .i_rst_n     (reset_n),
    .i_fire      (w_fire),
    .i_data      (w_data),
    .i_tag       (r_state == OWN1),
    .o_tag       (w_tag),
    .i_full      (bus.FULL),
    .o_di        (bus.DI),
    .o_wren      (w_wren),
    .o_hw        (w_hw),
    .o_out_valid (w_out_valid)
  );

  // Count each FIFO write against the source that loaded the word
  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_wren) begin
      if (w_tag) r_cnt1 <= r_cnt1 + 32'd1;
      else       r_cnt0 <= r_cnt0 + 32'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`else
  wr_arb_pack u_pack (
    .i_clk       (ifclk),
    .i_rst_n     (reset_n),
    .i_fire      (w_fire),
    .i_data      (w_data),
    .i_full      (bus.FULL),
    .o_di        (bus.DI),
    .o_wren      (w_wren),
    .o_hw        (w_hw),
    .o_out_valid (w_out_valid)
  );

  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_memfifo_wr_arbiter.sv
// tb_memfifo_wr_arbiter: scenario tasks driving both halfword sources and FIFO FULL,
// checked against a sequence model of what each source sent.
`timescale 1ns/1ps
module tb_memfifo_wr_arbiter;

  localparam int unsigned BURST = 2;
`ifdef WR_ARB_STATS_EN
  localparam logic [31:0] EXP_CNT0 = 32'd5;
  localparam logic [31:0] EXP_CNT1 = 32'd3;
`else
  localparam logic [31:0] EXP_CNT0 = 32'd0;
  localparam logic [31:0] EXP_CNT1 = 32'd0;
`endif

  logic        ifclk = 1'b0;
  logic        reset_n;
  logic [1:0]  en;
  logic [1:0]  grant;
  logic [31:0] cnt0, cnt1;

  memfifo_wr_arbiter_if bus();

  memfifo_wr_arbiter #(.BURST(BURST)) dut (
    .ifclk   (ifclk),
    .reset_n (reset_n),
    .en      (en),
    .bus     (bus),
    .grant   (grant),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
  );

  always #5 ifclk = ~ifclk;

  int unsigned n_cmp, n_fail, cyc;
  int unsigned src_idx[2], lim[2], exp_idx[2];
  bit          rnd[2];
  bit          full_rnd;
  int unsigned acc_t[$];
  logic [1:0]  acc_g[$];
  bit          acc_s[$];
  logic [31:0] wq[$];
  int unsigned wr_t[$];
  int unsigned both_rdy, r1_seen;
  logic        smp_wren, smp_r0;
  logic [31:0] smp_di;
  logic [1:0]  smp_grant;

  // Source s sends halfword number idx as this value
  function automatic logic [15:0] model_hw(int unsigned s, int unsigned idx);
    return (s == 1 ? 16'h8000 : 16'h0000) | 16'(idx & 32'h7fff);
  endfunction

  // A word is two consecutive halfwords of one source, first one in the low half
  function automatic logic [31:0] model_word(int unsigned s, int unsigned idx);
    return {model_hw(s, idx + 1), model_hw(s, idx)};
  endfunction

  task automatic drive_src();
    bus.s0_valid = (lim[0] != 0) && (!rnd[0] || $urandom_range(0, 3) != 0);
    bus.s0_data  = model_hw(0, src_idx[0]);
    bus.s1_valid = (lim[1] != 0) && (!rnd[1] || $urandom_range(0, 3) != 0);
    bus.s1_data  = model_hw(1, src_idx[1]);
    if (full_rnd) bus.FULL = 1'($urandom_range(0, 1));
  endtask

  // One clock: observe at the falling edge, advance stimulus just after the rising edge
  task automatic tick();
    bit f0, f1;
    @(negedge ifclk);
    f0 = bus.s0_valid && bus.s0_ready;
    f1 = bus.s1_valid && bus.s1_ready;
    smp_wren = bus.WREN; smp_di = bus.DI; smp_r0 = bus.s0_ready; smp_grant = grant;
    if (f0) begin acc_t.push_back(cyc); acc_g.push_back(grant); acc_s.push_back(1'b0); end
    if (f1) begin acc_t.push_back(cyc); acc_g.push_back(grant); acc_s.push_back(1'b1); end
    if (bus.WREN) begin wq.push_back(bus.DI); wr_t.push_back(cyc); end
    if (bus.s0_ready && bus.s1_ready) both_rdy++;
    if (bus.s1_ready) r1_seen++;
    @(posedge ifclk);
    #1;
    cyc++;
    if (f0) begin src_idx[0]++; lim[0]--; end
    if (f1) begin src_idx[1]++; lim[1]--; end
    drive_src();
  endtask

  task automatic clear_log();
    acc_t.delete(); acc_g.delete(); acc_s.delete(); wq.delete(); wr_t.delete();
    both_rdy = 0; r1_seen = 0;
  endtask

  task automatic apply_reset();
    lim[0] = 0; lim[1] = 0; rnd[0] = 0; rnd[1] = 0; full_rnd = 0;
    bus.FULL = 1'b0; en = 2'b00;
    drive_src();
    reset_n = 1'b0;
    repeat (2) @(posedge ifclk);
    #1 reset_n = 1'b1;
    clear_log();
    exp_idx[0] = src_idx[0]; exp_idx[1] = src_idx[1];
  endtask

  task automatic test_reset();
    logic [79:0] got;
    en = 2'b11; lim[0] = 2; lim[1] = 2; drive_src();
    reset_n = 1'b0;
    #1;
    got = {bus.DI, bus.WREN, bus.s0_ready, bus.s1_ready, grant, 11'd0, cnt0 | cnt1};
    n_cmp++;
    if (bus.DI !== 32'd0) begin n_fail++; $display("FAIL reset_DI: got %h want 0", bus.DI); end
    n_cmp++;
    if (bus.WREN !== 1'b0) begin n_fail++; $display("FAIL reset_WREN: got %b want 0", bus.WREN); end
    n_cmp++;
    if ({bus.s0_ready, bus.s1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {bus.s0_ready, bus.s1_ready}); end
    n_cmp++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_cmp++;
    if (cnt0 !== 32'd0) begin n_fail++; $display("FAIL reset_cnt0: got %0d want 0", cnt0); end
    n_cmp++;
    if (cnt1 !== 32'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d want 0", cnt1); end
    repeat (3) @(posedge ifclk);
    #1;
    n_cmp++;
    if ({bus.s0_ready, bus.s1_ready, grant} !== 4'b0000)
      begin n_fail++; $display("FAIL reset_held: got ready/grant %b want 0000 (raw %h)", {bus.s0_ready, bus.s1_ready, grant}, got); end
    apply_reset();
  endtask

  task automatic test_single();
    int unsigned t0, bad;
    logic [31:0] w;
    apply_reset();
    src_idx[0] = 1; exp_idx[0] = 1;
    en = 2'b01; lim[0] = 4; lim[1] = 6;
    drive_src();
    t0 = cyc;
    repeat (12) tick();
    n_cmp++;
    if (wq.size() != 2) begin n_fail++; $display("FAIL single_nwords: got %0d want 2", wq.size()); end
    w = (wq.size() > 0) ? wq[0] : 'x;
    n_cmp++;
    if (w !== 32'h0002_0001) begin n_fail++; $display("FAIL single_w0: got %h want 00020001", w); end
    w = (wq.size() > 1) ? wq[1] : 'x;
    n_cmp++;
    if (w !== 32'h0004_0003) begin n_fail++; $display("FAIL single_w1: got %h want 00040003", w); end
    n_cmp++;
    if (acc_t.size() == 0 || acc_t[0] - t0 != 1)
      begin n_fail++; $display("FAIL single_first_ready: got %0d want 1", acc_t.size() ? acc_t[0] - t0 : 999); end
    n_cmp++;
    if (wr_t.size() < 2 || wr_t[0] - t0 != 3 || wr_t[1] - t0 != 5)
      begin n_fail++; $display("FAIL single_wren_cycles: got %0d/%0d want 3/5", wr_t.size() ? wr_t[0] - t0 : 999, wr_t.size() > 1 ? wr_t[1] - t0 : 999); end
    bad = 0;
    foreach (acc_g[i]) if (acc_g[i] !== 2'b01 || acc_s[i]) bad++;
    n_cmp++;
    if (bad != 0 || acc_g.size() != 4) begin n_fail++; $display("FAIL single_owner: got %0d bad of %0d accepts want 0 of 4", bad, acc_g.size()); end
    n_cmp++;
    if (r1_seen != 0) begin n_fail++; $display("FAIL single_s1_ready: got %0d cycles want 0", r1_seen); end
    n_cmp++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", grant); end
  endtask

  task automatic test_round_robin();
    int unsigned t0;
    logic [1:0]  rg[$];
    int unsigned rl[$];
    logic [1:0]  eg;
    int unsigned s;
    apply_reset();
    en = 2'b11; lim[0] = 16; lim[1] = 16;
    drive_src();
    t0 = cyc;
    repeat (40) tick();
    foreach (acc_g[i]) begin
      if (rg.size() == 0 || rg[rg.size() - 1] !== acc_g[i]) begin rg.push_back(acc_g[i]); rl.push_back(1); end
      else rl[rl.size() - 1] = rl[rl.size() - 1] + 1;
    end
    n_cmp++;
    if (rg.size() != 8) begin n_fail++; $display("FAIL rr_nruns: got %0d want 8", rg.size()); end
    foreach (rg[i]) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (rg[i] !== eg || rl[i] != 2 * BURST)
        begin n_fail++; $display("FAIL rr_run[%0d]: got grant %b x%0d halfwords want %b x%0d", i, rg[i], rl[i], eg, 2 * BURST); end
    end
    n_cmp++;
    if (acc_t.size() != 32 || acc_t[acc_t.size() - 1] - t0 != 32)
      begin n_fail++; $display("FAIL rr_no_gap: got %0d accepts ending at %0d want 32 ending at 32", acc_t.size(), acc_t.size() ? acc_t[acc_t.size() - 1] - t0 : 0); end
    n_cmp++;
    if (wq.size() != 16) begin n_fail++; $display("FAIL rr_nwords: got %0d want 16", wq.size()); end
    foreach (wq[i]) begin
      s = wq[i][15];
      n_cmp++;
      if (wq[i] !== model_word(s, exp_idx[s])) begin n_fail++; $display("FAIL rr_word[%0d]: got %h want %h", i, wq[i], model_word(s, exp_idx[s])); end
      exp_idx[s] += 2;
    end
    n_cmp++;
    if (both_rdy != 0) begin n_fail++; $display("FAIL rr_ready_excl: got %0d cycles want 0", both_rdy); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w1;
    int unsigned s, guard, n0;
    apply_reset();
    en = 2'b01; lim[0] = 8;
    drive_src();
    w1 = model_word(0, exp_idx[0]);
    repeat (3) tick();
    bus.FULL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (smp_wren !== 1'b0 || smp_di !== w1)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got WREN %b DI %h want 0 %h", k, smp_wren, smp_di, w1); end
      if (k >= 1) begin
        n_cmp++;
        if (smp_r0 !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", k, smp_r0); end
      end
    end
    bus.FULL = 1'b0;
    tick();
    n_cmp++;
    if (smp_wren !== 1'b1 || smp_di !== w1 || smp_r0 !== 1'b1)
      begin n_fail++; $display("FAIL bp_resume: got WREN %b DI %h ready %b want 1 %h 1", smp_wren, smp_di, smp_r0, w1); end
    repeat (12) tick();
    n_cmp++;
    if (wq.size() != 4) begin n_fail++; $display("FAIL bp_nwords: got %0d want 4", wq.size()); end
    foreach (wq[i]) begin
      n_cmp++;
      if (wq[i] !== model_word(0, exp_idx[0])) begin n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, wq[i], model_word(0, exp_idx[0])); end
      exp_idx[0] += 2;
    end
    // randomized valids and FULL with both sources enabled
    clear_log();
    exp_idx[0] = src_idx[0]; exp_idx[1] = src_idx[1];
    en = 2'b11; rnd[0] = 1; rnd[1] = 1; lim[0] = 40; lim[1] = 40; full_rnd = 1;
    drive_src();
    guard = 0;
    while ((lim[0] != 0 || lim[1] != 0) && guard < 4000) begin tick(); guard++; end
    full_rnd = 0; bus.FULL = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (lim[0] != 0 || lim[1] != 0) begin n_fail++; $display("FAIL rnd_timeout: got %0d/%0d left want 0/0", lim[0], lim[1]); end
    n_cmp++;
    if (wq.size() != 40) begin n_fail++; $display("FAIL rnd_nwords: got %0d want 40", wq.size()); end
    n0 = 0;
    foreach (wq[i]) begin
      s = wq[i][15];
      if (s == 0) n0++;
      n_cmp++;
      if (wq[i] !== model_word(s, exp_idx[s])) begin n_fail++; $display("FAIL rnd_word[%0d]: got %h want %h", i, wq[i], model_word(s, exp_idx[s])); end
      exp_idx[s] += 2;
    end
    n_cmp++;
    if (n0 != 20) begin n_fail++; $display("FAIL rnd_split: got %0d s0 words want 20", n0); end
    n_cmp++;
    if (both_rdy != 0) begin n_fail++; $display("FAIL rnd_ready_excl: got %0d cycles want 0", both_rdy); end
  endtask

  task automatic test_mid_release();
    int unsigned n1;
    apply_reset();
    en = 2'b01; lim[0] = 2; lim[1] = 4;
    drive_src();
    repeat (2) tick();
    en = 2'b00;
    tick();
    n_cmp++;
    if (smp_r0 !== 1'b1 || smp_grant !== 2'b01)
      begin n_fail++; $display("FAIL mid_second_hw: got ready %b grant %b want 1 01", smp_r0, smp_grant); end
    repeat (6) tick();
    n_cmp++;
    if (wq.size() != 1 || wq[0] !== model_word(0, exp_idx[0]))
      begin n_fail++; $display("FAIL mid_word: got %0d words first %h want 1 %h", wq.size(), wq.size() ? wq[0] : 32'hx, model_word(0, exp_idx[0])); end
    n1 = 0;
    foreach (acc_s[i]) if (acc_s[i]) n1++;
    n_cmp++;
    if (acc_s.size() != 2 || n1 != 0) begin n_fail++; $display("FAIL mid_accepts: got %0d (%0d from s1) want 2 (0)", acc_s.size(), n1); end
    n_cmp++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL mid_release: got %b want 00", grant); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    en = 2'b01; lim[0] = 20;
    drive_src();
    repeat (3) tick();
    bus.FULL = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.DI !== 32'd0 || bus.WREN !== 1'b0 || bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0 || grant !== 2'b00)
      begin n_fail++; $display("FAIL rstmid_outputs: got DI %h WREN %b rdy %b%b grant %b want 0 0 00 00", bus.DI, bus.WREN, bus.s0_ready, bus.s1_ready, grant); end
    #3 reset_n = 1'b1;
    bus.FULL = 1'b0;
    lim[0] = 4;
    drive_src();
    clear_log();
    exp_idx[0] = src_idx[0];
    repeat (12) tick();
    n_cmp++;
    if (wq.size() != 2) begin n_fail++; $display("FAIL rstmid_nwords: got %0d want 2", wq.size()); end
    foreach (wq[i]) begin
      n_cmp++;
      if (wq[i] !== model_word(0, exp_idx[0])) begin n_fail++; $display("FAIL rstmid_word[%0d]: got %h want %h", i, wq[i], model_word(0, exp_idx[0])); end
      exp_idx[0] += 2;
    end
  endtask

  task automatic test_stats();
    apply_reset();
    en = 2'b01; lim[0] = 10;
    drive_src();
    repeat (16) tick();
    en = 2'b10; lim[1] = 6;
    drive_src();
    repeat (12) tick();
    n_cmp++;
    if (wq.size() != 8) begin n_fail++; $display("FAIL stats_nwords: got %0d want 8", wq.size()); end
    n_cmp++;
    if (cnt0 !== EXP_CNT0) begin n_fail++; $display("FAIL stats_cnt0: got %0d want %0d", cnt0, EXP_CNT0); end
    n_cmp++;
    if (cnt1 !== EXP_CNT1) begin n_fail++; $display("FAIL stats_cnt1: got %0d want %0d", cnt1, EXP_CNT1); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    src_idx[0] = 1; src_idx[1] = 0; exp_idx[0] = 1; exp_idx[1] = 0;
    lim[0] = 0; lim[1] = 0; rnd[0] = 0; rnd[1] = 0; full_rnd = 0;
    reset_n = 1'b1; en = 2'b00; bus.FULL = 1'b0;
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; bus.s0_data = '0; bus.s1_data = '0;
    clear_log();
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mid_release();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
